// File: rtl/phase_sequencer_pkg.sv
// Shared sizing, state encoding and row-count helper for the phase sequencer.
package phase_sequencer_pkg;

  localparam int N = 4;
  localparam int L = 8;
  localparam int K = 16;

  function automatic int clog2(int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int SW = clog2(K / N + 1);
  localparam int RW = clog2(L * K / N + 2 * N + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  function automatic logic [RW-1:0] calc_first_pass_rows(
    logic [SW-1:0] blk
  );
    logic [RW-1:0] b;
    b = RW'(blk);
    return RW'(L) * b + RW'(L) - RW'(N) * b;
  endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Step engine handshake between the phase sequencer and the step engine.
interface phase_sequencer_if;
  import phase_sequencer_pkg::*;

  logic          step_start;
  logic [SW-1:0] step_col;
  logic          step_first;
  logic          step_done;
  logic          step_fail;

  modport master (
    output step_start, step_col, step_first,
    input  step_done, step_fail
  );

  modport slave (
    input  step_start, step_col, step_first,
    output step_done, step_fail
  );

endinterface

// File: rtl/phase_sequencer.sv
// Walks a runtime-selected range of column blocks, one engine step per block,
// with failure, abort and completed-step reporting.
module phase_sequencer
  import phase_sequencer_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [SW-1:0] start_block,
  input  logic          init_left,
  input  logic          init_right,
  input  logic          abort,
  phase_sequencer_if.master step,
  output logic [RW-1:0] first_pass_rows,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic          aborted,
  output logic [SW-1:0] steps_run
);

  state_t        state_q, state_d;
  logic [SW-1:0] col_q, col_d;
  logic [SW-1:0] max_q, max_d;
  logic [SW-1:0] run_q, run_d;
  logic [RW-1:0] fpr_q, fpr_d;
  logic          fail_q, fail_d;
  logic          first_q, first_d;
  logic          done_q, done_d;
  logic          abt_q, abt_d;
  logic          ss_q, ss_d;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    max_d   = max_q;
    run_d   = run_q;
    fpr_d   = fpr_q;
    fail_d  = fail_q;
    first_d = first_q;
    done_d  = 1'b0;
    abt_d   = 1'b0;
    ss_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (init_left)
          max_d = SW'(L / N - 1);
        else if (init_right)
          max_d = SW'(K / N - 1);
        if (start) begin
          fpr_d  = calc_first_pass_rows(start_block);
          fail_d = 1'b0;
          run_d  = '0;
          // An empty range completes at once without touching step_col
          if (start_block > max_q) begin
            done_d = 1'b1;
          end else begin
            col_d   = start_block;
            first_d = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (abort) begin
          abt_d   = 1'b1;
          first_d = 1'b0;
          state_d = IDLE;
        end else begin
          ss_d    = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (abort) begin
          abt_d   = 1'b1;
          first_d = 1'b0;
          state_d = IDLE;
        end else if (step.step_fail) begin
          fail_d  = 1'b1;
          first_d = 1'b0;
          state_d = IDLE;
        end else if (step.step_done) begin
          run_d   = run_q + SW'(1);
          first_d = 1'b0;
          if (col_q == max_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            col_d   = col_q + SW'(1);
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      max_q   <= SW'(K / N - 1);
      run_q   <= '0;
      fpr_q   <= '0;
      fail_q  <= 1'b0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
      abt_q   <= 1'b0;
      ss_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      max_q   <= max_d;
      run_q   <= run_d;
      fpr_q   <= fpr_d;
      fail_q  <= fail_d;
      first_q <= first_d;
      done_q  <= done_d;
      abt_q   <= abt_d;
      ss_q    <= ss_d;
    end
  end

  assign step.step_start = ss_q;
  assign step.step_col   = col_q;
  assign step.step_first = first_q;
  assign first_pass_rows = fpr_q;
  assign busy            = (state_q != IDLE);
  assign done            = done_q;
  assign fail            = fail_q;
  assign aborted         = abt_q;
  assign steps_run       = run_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Stand-alone bench: behavioural step engine plus a range/outcome model of
// each phase, directed scenarios followed by randomized phases.
module tb_phase_sequencer;
  import phase_sequencer_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [SW-1:0] start_block;
  logic          init_left;
  logic          init_right;
  logic          abort;
  logic [RW-1:0] first_pass_rows;
  logic          busy;
  logic          done;
  logic          fail;
  logic          aborted;
  logic [SW-1:0] steps_run;

  phase_sequencer_if sif();

  int total  = 0;
  int passed = 0;
  int exp_max;

  always #5 clk = ~clk;

  phase_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .start_block    (start_block),
    .init_left      (init_left),
    .init_right     (init_right),
    .abort          (abort),
    .step           (sif.master),
    .first_pass_rows(first_pass_rows),
    .busy           (busy),
    .done           (done),
    .fail           (fail),
    .aborted        (aborted),
    .steps_run      (steps_run)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(string tag, logic [31:0] obs, int expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: got %0d, expected %0d", tag, obs, expv);
  endtask

  task automatic do_init(int which);
    if (which == 1) begin
      init_left = 1'b1;
      exp_max   = L / N - 1;
    end else if (which == 2) begin
      init_right = 1'b1;
      exp_max    = K / N - 1;
    end
    tick;
    init_left  = 1'b0;
    init_right = 1'b0;
  endtask

  task automatic wait_ss(string tag);
    int n;
    n = 0;
    while (sif.step_start !== 1'b1 && n < 8) begin
      tick;
      n++;
    end
    chk(tag, n, 1);
  endtask

  task automatic run_phase(int sb, int fail_k, int abort_k, bit poke);
    int nsteps;
    int lat;
    nsteps = (sb > exp_max) ? 0 : exp_max - sb + 1;
    start       = 1'b1;
    start_block = SW'(sb);
    tick;
    start = 1'b0;
    chk("fpr", first_pass_rows, L * sb + L - N * sb);
    chk("fail_clr", fail, 0);
    chk("run_clr", steps_run, 0);
    if (nsteps == 0) begin
      chk("empty_done", done, 1);
      chk("empty_busy", busy, 0);
      chk("empty_first", sif.step_first, 0);
      tick;
      chk("empty_done_pulse", done, 0);
      chk("empty_no_ss", sif.step_start, 0);
      tick;
      chk("empty_no_ss2", sif.step_start, 0);
      chk("empty_idle", busy, 0);
      return;
    end
    chk("busy_on", busy, 1);
    chk("first_on", sif.step_first, 1);
    for (int k = 0; k < nsteps; k++) begin
      wait_ss("ss_latency");
      chk("step_col", sif.step_col, sb + k);
      chk("step_first", sif.step_first, (k == 0) ? 1 : 0);
      chk("busy_step", busy, 1);
      lat = $urandom_range(1, 4);
      for (int i = 0; i < lat; i++) begin
        if (poke && k == 0 && i == 0) begin
          start       = 1'b1;
          start_block = '0;
          init_left   = 1'b1;
        end
        tick;
        start     = 1'b0;
        init_left = 1'b0;
        if (i == 0) chk("ss_pulse", sif.step_start, 0);
      end
      if (k == abort_k) begin
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_pulse", aborted, 1);
        chk("abort_busy", busy, 0);
        chk("abort_no_done", done, 0);
        chk("abort_run", steps_run, k);
        chk("abort_fail", fail, 0);
        tick;
        chk("abort_once", aborted, 0);
        tick;
        sif.step_done = 1'b1;
        tick;
        sif.step_done = 1'b0;
        chk("late_done", done, 0);
        chk("late_busy", busy, 0);
        chk("late_run", steps_run, k);
        chk("late_ss", sif.step_start, 0);
        tick;
        chk("late_ss2", sif.step_start, 0);
        return;
      end
      if (k == fail_k) begin
        sif.step_done = 1'b1;
        sif.step_fail = 1'b1;
        tick;
        sif.step_done = 1'b0;
        sif.step_fail = 1'b0;
        chk("fail_set", fail, 1);
        chk("fail_busy", busy, 0);
        chk("fail_no_done", done, 0);
        chk("fail_run", steps_run, k);
        chk("fail_col", sif.step_col, sb + k);
        chk("fail_first", sif.step_first, 0);
        tick;
        tick;
        chk("fail_sticky", fail, 1);
        chk("fail_no_ss", sif.step_start, 0);
        return;
      end
      sif.step_done = 1'b1;
      tick;
      sif.step_done = 1'b0;
      chk("run_count", steps_run, k + 1);
      chk("first_clr", sif.step_first, 0);
      if (k == nsteps - 1) begin
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        tick;
        chk("done_once", done, 0);
      end else begin
        chk("no_early_done", done, 0);
        chk("busy_mid", busy, 1);
      end
    end
  endtask

  initial begin
    int which;
    int sb;
    int mode;
    int ns;
    int fk;
    int ak;
    rst           = 1'b1;
    start         = 1'b0;
    start_block   = '0;
    init_left     = 1'b0;
    init_right    = 1'b0;
    abort         = 1'b0;
    sif.step_done = 1'b0;
    sif.step_fail = 1'b0;
    exp_max       = K / N - 1;
    tick;
    tick;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_ss", sif.step_start, 0);
    chk("rst_col", sif.step_col, 0);
    chk("rst_first", sif.step_first, 0);
    chk("rst_fpr", first_pass_rows, 0);
    chk("rst_run", steps_run, 0);
    rst = 1'b0;
    tick;

    do_init(2);
    run_phase(0, -1, -1, 1'b0);
    do_init(1);
    run_phase(1, -1, -1, 1'b0);
    do_init(2);
    run_phase(2, 1, -1, 1'b0);
    run_phase(0, -1, 1, 1'b0);
    run_phase(5, -1, -1, 1'b0);
    run_phase(0, -1, -1, 1'b1);

    do_init(1);
    start       = 1'b1;
    start_block = '0;
    tick;
    start = 1'b0;
    wait_ss("rst_phase_ss");
    rst = 1'b1;
    tick;
    rst     = 1'b0;
    exp_max = K / N - 1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_aborted", aborted, 0);
    chk("mid_rst_ss", sif.step_start, 0);
    chk("mid_rst_col", sif.step_col, 0);
    chk("mid_rst_first", sif.step_first, 0);
    chk("mid_rst_fpr", first_pass_rows, 0);
    chk("mid_rst_run", steps_run, 0);
    chk("mid_rst_fail", fail, 0);
    run_phase(0, -1, -1, 1'b0);

    for (int r = 0; r < 10; r++) begin
      which = $urandom_range(0, 2);
      do_init(which);
      sb   = $urandom_range(0, 5);
      mode = $urandom_range(0, 2);
      ns   = (sb > exp_max) ? 0 : exp_max - sb + 1;
      fk   = (mode == 1 && ns > 0) ? $urandom_range(0, ns - 1) : -1;
      ak   = (mode == 2 && ns > 0) ? $urandom_range(0, ns - 1) : -1;
      run_phase(sb, fk, ak, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
